// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the Wishbone bus arbiter.
package wb_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        OWNED     = 2'd1,
        FORCE_ERR = 2'd2
    } arb_state_t;

    // Wishbone cycle type identifiers
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    // Bus field widths
    localparam int ADR_W = 30;
    localparam int DAT_W = 32;
    localparam int SEL_W = 4;
    localparam int CTI_W = 3;
    localparam int BTE_W = 2;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: searches the request vector starting
// one position after last and wraps around; returns a one-hot winner.
module rr_priority_picker #(
    parameter  int N     = 2,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     winner,
    output logic             valid
);

    logic [IDX_W-1:0] idx;

    // First requester after last (wrapping) wins; last itself is checked last
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= N; k++) begin
            idx = IDX_W'((int'(last) + k) % N);
            if (!valid && req[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wishbone_bus_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave port between NUM_MASTERS
// masters. The grant is held for the whole cyc; a watchdog turns a missing
// ack into a one-cycle forced err so a dead slave cannot hang a master.
//
// Handshake: a master frames its ownership with cyc; a beat is offered while
// stb is high and completes in the cycle the slave returns ack (or err).
// There is no separate ready: ack/err is the acceptance strobe.
module wishbone_bus_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int TIMEOUT     = 1024,
    parameter int CNT_W       = 8
) (
    input  logic                      clk_sys,
    input  logic                      reset_n,
    input  logic [NUM_MASTERS*30-1:0] m_adr,
    input  logic [NUM_MASTERS*32-1:0] m_dat_w,
    input  logic [NUM_MASTERS*4-1:0]  m_sel,
    input  logic [NUM_MASTERS*3-1:0]  m_cti,
    input  logic [NUM_MASTERS*2-1:0]  m_bte,
    input  logic [NUM_MASTERS-1:0]    m_cyc,
    input  logic [NUM_MASTERS-1:0]    m_stb,
    input  logic [NUM_MASTERS-1:0]    m_we,
    output logic [NUM_MASTERS-1:0]    m_ack,
    output logic [NUM_MASTERS-1:0]    m_err,
    output logic [31:0]               m_dat_r,
    output logic [29:0]               s_adr,
    output logic [31:0]               s_dat_w,
    output logic [3:0]                s_sel,
    output logic [2:0]                s_cti,
    output logic [1:0]                s_bte,
    output logic                      s_cyc,
    output logic                      s_stb,
    output logic                      s_we,
    input  logic                      s_ack,
    input  logic                      s_err,
    input  logic [31:0]               s_dat_r,
    output logic [NUM_MASTERS-1:0]    grant,
    output logic [CNT_W-1:0]          timeout_count,
    output logic [1:0]                arb_state
);

    localparam int IDX_W  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int WDOG_W = $clog2(TIMEOUT);
    localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(TIMEOUT - 1);

    arb_state_t               state, state_n;
    logic [NUM_MASTERS-1:0]   grant_n;
    logic [IDX_W-1:0]         last_grant, last_grant_n;
    logic [IDX_W-1:0]         g_idx;
    logic [WDOG_W-1:0]        wdog, wdog_n;
    logic [CNT_W-1:0]         timeout_count_n;
    logic [NUM_MASTERS-1:0]   pick_winner;
    logic                     pick_valid;
    logic                     mux_cyc, mux_stb;

    rr_priority_picker #(.N(NUM_MASTERS)) u_picker (
        .req    (m_cyc),
        .last   (last_grant),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    assign m_dat_r   = s_dat_r;
    assign arb_state = state;

    // Index of the current owner, derived from the one-hot grant
    always_comb begin
        g_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant[i]) g_idx = IDX_W'(i);
        end
    end

    // State, grant, round-robin pointer, watchdog and event counter
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            grant         <= '0;
            last_grant    <= IDX_W'(NUM_MASTERS - 1);
            wdog          <= '0;
            timeout_count <= '0;
        end else begin
            state         <= state_n;
            grant         <= grant_n;
            last_grant    <= last_grant_n;
            wdog          <= wdog_n;
            timeout_count <= timeout_count_n;
        end
    end

    // Next-state: arbitrate in IDLE, hold grant while cyc, watchdog in OWNED
    always_comb begin
        state_n         = state;
        grant_n         = grant;
        last_grant_n    = last_grant;
        wdog_n          = wdog;
        timeout_count_n = timeout_count;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    grant_n = pick_winner;
                    wdog_n  = '0;
                    state_n = OWNED;
                end
            end
            OWNED: begin
                if (!m_cyc[g_idx]) begin
                    last_grant_n = g_idx;
                    grant_n      = '0;
                    state_n      = IDLE;
                end else if (s_ack || s_err) begin
                    // A response on the limit cycle still wins over the timeout
                    wdog_n = '0;
                end else if (s_stb) begin
                    if (wdog == WDOG_MAX) state_n = FORCE_ERR;
                    else                  wdog_n  = wdog + 1'b1;
                end
            end
            FORCE_ERR: begin
                if (timeout_count != '1) timeout_count_n = timeout_count + 1'b1;
                last_grant_n = g_idx;
                grant_n      = '0;
                state_n      = IDLE;
            end
            default: begin
                grant_n = '0;
                state_n = IDLE;
            end
        endcase
    end

    // Slave-side mux of the owner's signals and response routing to the owner
    always_comb begin
        s_adr   = '0;
        s_dat_w = '0;
        s_sel   = '0;
        s_cti   = '0;
        s_bte   = '0;
        s_we    = 1'b0;
        mux_cyc = 1'b0;
        mux_stb = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant[i]) begin
                s_adr   = m_adr[ADR_W*i +: ADR_W];
                s_dat_w = m_dat_w[DAT_W*i +: DAT_W];
                s_sel   = m_sel[SEL_W*i +: SEL_W];
                s_cti   = m_cti[CTI_W*i +: CTI_W];
                s_bte   = m_bte[BTE_W*i +: BTE_W];
                s_we    = m_we[i];
                mux_cyc = m_cyc[i];
                mux_stb = m_stb[i];
            end
        end
        s_cyc = (state == OWNED) && mux_cyc;
        s_stb = (state == OWNED) && mux_stb;
        m_ack = '0;
        m_err = '0;
        if (state == OWNED) begin
            m_ack = grant & {NUM_MASTERS{s_ack}};
            m_err = grant & {NUM_MASTERS{s_err}};
        end else if (state == FORCE_ERR) begin
            m_err = grant;
        end
    end

endmodule

// File: tb/tb_wishbone_bus_arbiter.sv
// Bench for wishbone_bus_arbiter with two masters and a short watchdog.
module tb_wishbone_bus_arbiter;
    import wb_arb_pkg::*;

    localparam int NM = 2;
    localparam int TO = 16;
    localparam int CW = 8;

    logic              clk_sys = 1'b0;
    logic              reset_n;
    logic [NM*30-1:0]  m_adr;
    logic [NM*32-1:0]  m_dat_w;
    logic [NM*4-1:0]   m_sel;
    logic [NM*3-1:0]   m_cti;
    logic [NM*2-1:0]   m_bte;
    logic [NM-1:0]     m_cyc, m_stb, m_we;
    logic [NM-1:0]     m_ack, m_err;
    logic [31:0]       m_dat_r;
    logic [29:0]       s_adr;
    logic [31:0]       s_dat_w;
    logic [3:0]        s_sel;
    logic [2:0]        s_cti;
    logic [1:0]        s_bte;
    logic              s_cyc, s_stb, s_we;
    logic              s_ack, s_err;
    logic [31:0]       s_dat_r;
    logic [NM-1:0]     grant;
    logic [CW-1:0]     timeout_count;
    logic [1:0]        arb_state;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_e;

    wishbone_bus_arbiter #(.NUM_MASTERS(NM), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .m_adr(m_adr), .m_dat_w(m_dat_w), .m_sel(m_sel), .m_cti(m_cti), .m_bte(m_bte),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
        .m_ack(m_ack), .m_err(m_err), .m_dat_r(m_dat_r),
        .s_adr(s_adr), .s_dat_w(s_dat_w), .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we),
        .s_ack(s_ack), .s_err(s_err), .s_dat_r(s_dat_r),
        .grant(grant), .timeout_count(timeout_count), .arb_state(arb_state)
    );

    // Clock
    always #5 clk_sys = ~clk_sys;

    // Hard bound on simulation time
    initial begin
        #50000;
        $display("FAIL global_timeout: time %0t, limit 50000", $time);
        $fatal(1, "simulation time bound exceeded");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] sb_word(input int m, input logic [29:0] adr);
        logic [1:0] oh;
        oh = 2'(1 << m);
        return {oh, adr};
    endfunction

    // Scoreboard: every acked beat must match the next expected {owner, address}
    always @(negedge clk_sys) begin
        if (reset_n && s_cyc && s_stb && s_ack) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_beat", 32'(exp_q.size()), 32'd1);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_beat", {grant, s_adr}, mon_e);
                check("sb_ack_route", {30'd0, m_ack}, {30'd0, mon_e[31:30]});
                check("sb_dat_r", m_dat_r, s_dat_r);
            end
        end
    end

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_sys);
    endtask

    task automatic clear_inputs();
        m_adr = '0; m_dat_w = '0; m_sel = '0; m_cti = '0; m_bte = '0;
        m_cyc = '0; m_stb = '0; m_we = '0;
        s_ack = 1'b0; s_err = 1'b0; s_dat_r = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_inputs();
        repeat (2) step();
        reset_n = 1'b1;
    endtask

    task automatic raise(input int m, input logic [29:0] adr, input logic we, input logic [31:0] dat);
        m_adr[30*m +: 30]   = adr;
        m_dat_w[32*m +: 32] = dat;
        m_sel[4*m +: 4]     = 4'hf;
        m_cti[3*m +: 3]     = CTI_CLASSIC;
        m_bte[2*m +: 2]     = 2'b00;
        m_we[m]             = we;
        m_cyc[m]            = 1'b1;
        m_stb[m]            = 1'b1;
    endtask

    task automatic drop(input int m);
        m_cyc[m] = 1'b0;
        m_stb[m] = 1'b0;
        m_we[m]  = 1'b0;
    endtask

    // Wait (bounded) for master m to be granted, complete one beat, release,
    // and optionally re-request right after the release.
    task automatic serve(input int m, input bit rearm, input logic [29:0] adr2);
        int n;
        n = 0;
        sample();
        while (grant == '0 && n < 20) begin
            step();
            sample();
            n++;
        end
        check("rr_grant", 32'(grant), 32'(1 << m));
        step();
        s_dat_r = $urandom;
        s_ack = 1'b1;
        sample();
        step();
        s_ack = 1'b0;
        drop(m);
        sample();
        check("release_s_cyc", 32'(s_cyc), 32'd0);
        step();
        if (rearm) begin
            raise(m, adr2, 1'b0, $urandom);
            exp_q.push_back(sb_word(m, adr2));
        end
        sample();
        check("handover_gap", 32'(grant), 32'd0);
        step();
    endtask

    initial begin
        logic [31:0] d;
        logic [29:0] a0, a1, a2, base;

        // Reset values
        reset_n = 1'b0;
        clear_inputs();
        #3;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_s_cyc", 32'(s_cyc), 32'd0);
        check("rst_m_ack", 32'(m_ack), 32'd0);
        check("rst_m_err", 32'(m_err), 32'd0);
        check("rst_tcount", 32'(timeout_count), 32'd0);
        check("rst_state", 32'(arb_state), 32'(IDLE));

        // Single master write with exact cycle timing
        do_reset();
        step();
        d = $urandom;
        raise(0, 30'h100, 1'b1, d);
        exp_q.push_back(sb_word(0, 30'h100));
        sample();
        check("single_lat_grant", 32'(grant), 32'd0);
        check("single_lat_cyc", 32'(s_cyc), 32'd0);
        step(); sample();
        check("single_grant", 32'(grant), 32'd1);
        check("single_s_cyc", 32'(s_cyc), 32'd1);
        check("single_s_adr", 32'(s_adr), 32'h100);
        check("single_s_we", 32'(s_we), 32'd1);
        check("single_s_dat_w", s_dat_w, d);
        step(); sample();
        check("single_no_ack", 32'(m_ack), 32'd0);
        step(); s_ack = 1'b1; sample();
        check("single_ack", 32'(m_ack), 32'd1);
        step(); s_ack = 1'b0; drop(0); sample();
        check("single_hold", 32'(grant), 32'd1);
        step(); sample();
        check("single_release", 32'(grant), 32'd0);

        // Simultaneous requests: 0 first, then alternation 1, 0
        do_reset();
        step();
        a0 = 30'($urandom_range(0, 32'h3fff_ffff));
        a1 = 30'($urandom_range(0, 32'h3fff_ffff));
        a2 = 30'($urandom_range(0, 32'h3fff_ffff));
        raise(0, a0, 1'b0, $urandom);
        raise(1, a1, 1'b1, $urandom);
        exp_q.push_back(sb_word(0, a0));
        exp_q.push_back(sb_word(1, a1));
        serve(0, 1'b1, a2);
        serve(1, 1'b0, '0);
        serve(0, 1'b0, '0);

        // Locked grant across a 4-beat incrementing burst
        do_reset();
        step();
        base = 30'h2000;
        raise(1, base, 1'b0, $urandom);
        for (int k = 0; k < 4; k++) exp_q.push_back(sb_word(1, base + 30'(k)));
        for (int k = 0; k < 4; k++) begin
            step();
            m_adr[30 +: 30] = base + 30'(k);
            m_cti[3 +: 3]   = (k == 3) ? CTI_END : CTI_INCR;
            s_dat_r = $urandom;
            s_ack = 1'b1;
            if (k == 1) begin
                raise(0, 30'h3f0, 1'b1, $urandom);
                exp_q.push_back(sb_word(0, 30'h3f0));
            end
            sample();
            check("locked_ack0", 32'(m_ack[0]), 32'd0);
            check("locked_grant", 32'(grant), 32'd2);
        end
        step(); s_ack = 1'b0; drop(1); sample();
        check("locked_tail_ack", 32'(m_ack), 32'd0);
        step();
        serve(0, 1'b0, '0);

        // Watchdog timeout with a silent slave, then a late ack
        do_reset();
        step();
        raise(0, 30'h040, 1'b0, $urandom);
        for (int c = 1; c <= TO; c++) begin
            step(); sample();
            check("wd_no_err", 32'(m_err), 32'd0);
            check("wd_s_cyc", 32'(s_cyc), 32'd1);
        end
        step(); s_ack = 1'b1; sample();
        check("wd_err", 32'(m_err), 32'd1);
        check("wd_err_s_cyc", 32'(s_cyc), 32'd0);
        check("wd_late_ack", 32'(m_ack), 32'd0);
        check("wd_state", 32'(arb_state), 32'(FORCE_ERR));
        step(); drop(0); sample();
        check("wd_err_once", 32'(m_err), 32'd0);
        check("wd_late_ack_idle", 32'(m_ack), 32'd0);
        check("wd_tcount", 32'(timeout_count), 32'd1);
        check("wd_release", 32'(grant), 32'd0);
        step(); s_ack = 1'b0; sample();
        check("wd_idle", 32'(grant), 32'd0);

        // Ack arriving on the watchdog limit cycle wins
        step();
        raise(0, 30'h050, 1'b0, $urandom);
        exp_q.push_back(sb_word(0, 30'h050));
        for (int c = 1; c < TO; c++) begin
            step(); sample();
            check("race_no_err", 32'(m_err), 32'd0);
        end
        step(); s_dat_r = $urandom; s_ack = 1'b1; sample();
        check("race_ack", 32'(m_ack), 32'd1);
        check("race_err", 32'(m_err), 32'd0);
        step(); s_ack = 1'b0; sample();
        check("race_after_err", 32'(m_err), 32'd0);
        check("race_still_owned", 32'(grant), 32'd1);
        step(); drop(0);
        step(); step(); sample();
        check("race_tcount", 32'(timeout_count), 32'd1);

        // Asynchronous reset in the middle of an owned write
        do_reset();
        step();
        raise(0, 30'h0aa, 1'b1, $urandom);
        raise(1, 30'h0bb, 1'b0, $urandom);
        step(); sample();
        check("areset_pre_grant", 32'(grant), 32'd1);
        step();
        s_ack = 1'b1;
        #1;
        check("areset_pre_ack", 32'(m_ack), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("areset_s_cyc", 32'(s_cyc), 32'd0);
        check("areset_s_stb", 32'(s_stb), 32'd0);
        check("areset_grant", 32'(grant), 32'd0);
        check("areset_m_ack", 32'(m_ack), 32'd0);
        s_ack = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
        sample();
        check("areset_release_idle", 32'(grant), 32'd0);
        step(); sample();
        check("areset_first_grant", 32'(grant), 32'd1);
        step();
        drop(0);
        drop(1);
        repeat (3) step();

        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
